seg7_scan_mux: RTL and testbench
================================

// Module: seg7_scan_mux
// PURPOSE
//  Time-multiplexed driver for the 4-digit common-anode 7-segment display; sits directly downstream of dp_logic.
//  Takes four hex/BCD digit nibbles plus dp_logic's 4-bit decimal-point pattern.
//  Scans digits 0..3 and drives active-low segment, dp and anode lines.
//  Double-buffers the data so a display update never tears mid-frame.
// PARAMETERS
//  SCAN_DIV   16384  clk cycles each digit is lit; legal range >= 2
//  CNT_W      15     prescaler width; must satisfy 2**CNT_W >= SCAN_DIV
// PORTS
//  clk        in   1   system clock, single clock domain
//  rst_n      in   1   asynchronous, active-low reset
//  digits_i   in   16  digit k = digits_i[4k+3:4k], value 0..F; digit 0 is rightmost
//  dp_i       in   4   decimal-point pattern from dp_logic, active high; bit k = digit k
//  upd_i      in   1   1-cycle strobe: capture digits_i/dp_i for display
//  seg_n      out  7   {g,f,e,d,c,b,a}, active low, registered
//  dp_n       out  1   decimal point of lit digit, active low, registered
//  an_n       out  4   anode enables, one-hot-low, registered
//  frame_o    out  1   1-cycle pulse on each frame boundary (digit 3 -> 0)
//  pending_o  out  1   captured data waiting for the next frame boundary
// BEHAVIOUR
//  Reset (async assert, sync release): an_n=4'hF, seg_n=7'h7F, dp_n=1, frame_o=0, pending_o=0;
//   prescaler=0, idx=0, stage and shadow registers=0.
//  Prescaler counts 0..SCAN_DIV-1 and wraps; tick = (cnt == SCAN_DIV-1).
//  On tick: idx <= idx+1 mod 4. Frame boundary = tick with idx==3.
//  Output registers load every cycle from the post-update idx and shadow.
//   First edge after reset release gives an_n=4'b1110 with digit 0 of shadow (0 -> seg_n=7'b1000000).
//   Anodes, segments and dp change on the same edge; there is no blanking gap.
//  Capture: upd_i=1 loads digits_i/dp_i into stage and sets pending.
//   Repeated upd_i before the boundary overwrites stage; the last value wins.
//  Shadow update happens at the frame boundary only, when pending=1: shadow <= stage, pending <= 0.
//  Boundary and upd_i in the same cycle: the inputs go straight into shadow and pending ends 0.
//  frame_o is registered and is high in the cycle after the boundary tick.
//  Decode: standard hex table, 0..9 then A,b,C,d,E,F. dp_n = ~shadow_dp[idx].
//  Reset mid-frame: all state returns to its reset value immediately, with no partial frame.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: blank digit k (k=3..1) if every shadow digit >= k is 0 and its dp bit is 0.
//   A blanked digit has seg_n=7'h7F, but its anode still scans.
//   Digit 0 is never blanked. A set dp bit keeps that digit and all lower digits visible.
//  LEADING_ZERO_BLANK_EN undefined: all four digits are always decoded (e.g. "0012").
// STRUCTURE
//  Package seg7_pkg:
//   NDIG=4
//   SEG_BLANK=7'h7F
//   16-entry active-low segment table constant SEG_LUT[0:15]
//   typedef digit_idx_t = 2-bit index
//  Sub-module seg7_hex_dec: combinational nibble -> seg_n lookup using SEG_LUT; one instance on the muxed nibble.
//  Top level holds the prescaler, idx counter, stage/shadow/pending registers, blank logic and output registers.
// TESTING  (bench uses SCAN_DIV=4)
//  1. Reset release, no upd: an_n cycles 1110,1101,1011,0111 every 4 clks; seg_n=7'b1000000; dp_n=1.
//  2. digits_i=16'h1234, dp_i=4'b0100, upd in mid-frame:
//     pending_o=1 until the boundary; next frame shows 4,3,2,1; dp_n=0 only when an_n=1011.
//  3. upd of 16'hAAAA then 16'h5555 in the same frame: the next frame shows only 5555.
//  4. upd coincident with the boundary tick: values appear in that new frame; pending_o stays 0.
//  5. rst_n low for 1 cycle mid-digit-2: outputs go to reset values asynchronously and scanning restarts at digit 0.
//  6. LEADING_ZERO_BLANK_EN, 16'h0012 dp=0: digits 3,2 give seg_n=7'h7F.
//     With dp_i=4'b1000: digits 3,2 decode as 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the 4-digit 7-segment scan driver.
//   NDIG       number of scanned digits
//   SEG_BLANK  active-low pattern with every segment off
//   SEG_LUT    active-low {g,f,e,d,c,b,a} pattern for nibble 0..F
//   digit_idx_t  2-bit digit index
package seg7_pkg;

  localparam int NDIG = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Standard hex glyphs: 0-9, A, b, C, d, E, F (segment lit = 0)
  localparam logic [6:0] SEG_LUT [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/seg7_hex_dec.sv
// seg7_hex_dec: combinational nibble to active-low segment decode.
//   nib_i     in  4  hex digit value 0..F
//   seg_n_o   out 7  {g,f,e,d,c,b,a}, active low
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_n_o
);

  assign seg_n_o = SEG_LUT[nib_i];

endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed driver for a 4-digit common-anode 7-segment
// display with double-buffered digit/decimal-point data.
//   clk        in   1   system clock
//   rst_n      in   1   asynchronous active-low reset
//   digits_i   in   16  digit k = digits_i[4k+3:4k], digit 0 rightmost
//   dp_i       in   4   decimal points, active high, bit k = digit k
//   upd_i      in   1   capture strobe for digits_i/dp_i
//   seg_n      out  7   {g,f,e,d,c,b,a} of the lit digit, active low
//   dp_n       out  1   decimal point of the lit digit, active low
//   an_n       out  4   anode enables, one-hot-low
//   frame_o    out  1   one-cycle pulse after each frame boundary
//   pending_o  out  1   captured data waiting for the next frame boundary
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 16384,
  parameter int CNT_W    = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits_i,
  input  logic [3:0]  dp_i,
  input  logic        upd_i,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [3:0]  an_n,
  output logic        frame_o,
  output logic        pending_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_idx_t       idx_q, idx_d;
  logic [15:0]      stage_dig_q, stage_dig_d;
  logic [3:0]       stage_dp_q, stage_dp_d;
  logic [15:0]      shadow_dig_q, shadow_dig_d;
  logic [3:0]       shadow_dp_q, shadow_dp_d;
  logic             pending_q, pending_d;
  logic [6:0]       seg_n_q, seg_n_d;
  logic             dp_n_q, dp_n_d;
  logic [3:0]       an_n_q, an_n_d;
  logic             frame_q, frame_d;

  logic             tick;
  logic             boundary;
  logic [3:0]       nibble;
  logic [6:0]       dec_seg_n;
  logic             blank;

  assign tick     = (cnt_q == CNT_MAX);
  assign boundary = tick && (idx_q == digit_idx_t'(NDIG - 1));

  // Scan counters and double buffer
  always_comb begin
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    idx_d        = tick ? idx_q + 1'b1 : idx_q;
    stage_dig_d  = stage_dig_q;
    stage_dp_d   = stage_dp_q;
    shadow_dig_d = shadow_dig_q;
    shadow_dp_d  = shadow_dp_q;
    pending_d    = pending_q;
    if (upd_i) begin
      stage_dig_d = digits_i;
      stage_dp_d  = dp_i;
    end
    if (boundary) begin
      // A strobe landing on the boundary bypasses the stage register
      if (upd_i) begin
        shadow_dig_d = digits_i;
        shadow_dp_d  = dp_i;
      end else if (pending_q) begin
        shadow_dig_d = stage_dig_q;
        shadow_dp_d  = stage_dp_q;
      end
      pending_d = 1'b0;
    end else if (upd_i) begin
      pending_d = 1'b1;
    end
  end

  // Outputs are computed from next-state idx/shadow so they line up with the
  // registered scan position without an extra cycle of lag.
  assign nibble = shadow_dig_d[{idx_d, 2'b00} +: 4];

  seg7_hex_dec u_dec (
    .nib_i   (nibble),
    .seg_n_o (dec_seg_n)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Walk from the top digit down; a digit is blank while every digit at or
  // above it is zero with its decimal point off. Digit 0 is never blank.
  always_comb begin
    logic lead_zero;
    lead_zero = 1'b1;
    blank     = 1'b0;
    for (int k = NDIG - 1; k >= 1; k--) begin
      lead_zero = lead_zero && (shadow_dig_d[4*k +: 4] == 4'h0) && !shadow_dp_d[k];
      if (digit_idx_t'(k) == idx_d) blank = lead_zero;
    end
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    seg_n_d = blank ? SEG_BLANK : dec_seg_n;
    dp_n_d  = ~shadow_dp_d[idx_d];
    an_n_d  = ~(4'b0001 << idx_d);
    frame_d = boundary;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      stage_dig_q  <= '0;
      stage_dp_q   <= '0;
      shadow_dig_q <= '0;
      shadow_dp_q  <= '0;
      pending_q    <= 1'b0;
      seg_n_q      <= SEG_BLANK;
      dp_n_q       <= 1'b1;
      an_n_q       <= 4'hF;
      frame_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      stage_dig_q  <= stage_dig_d;
      stage_dp_q   <= stage_dp_d;
      shadow_dig_q <= shadow_dig_d;
      shadow_dp_q  <= shadow_dp_d;
      pending_q    <= pending_d;
      seg_n_q      <= seg_n_d;
      dp_n_q       <= dp_n_d;
      an_n_q       <= an_n_d;
      frame_q      <= frame_d;
    end
  end

  assign seg_n     = seg_n_q;
  assign dp_n      = dp_n_q;
  assign an_n      = an_n_q;
  assign frame_o   = frame_q;
  assign pending_o = pending_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
module tb_seg7_scan_mux;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits_i = '0;
  logic [3:0]  dp_i = '0;
  logic        upd_i = 1'b0;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_o;
  logic        pending_o;

  seg7_scan_mux #(.SCAN_DIV(SD), .CNT_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digits_i  (digits_i),
    .dp_i      (dp_i),
    .upd_i     (upd_i),
    .seg_n     (seg_n),
    .dp_n      (dp_n),
    .an_n      (an_n),
    .frame_o   (frame_o),
    .pending_o (pending_o)
  );

  always #5 clk = ~clk;

  // Active-high glyphs {g,f,e,d,c,b,a}, the textbook hex table
  logic [6:0] glyph [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  // Reference model: n = clock edges since reset release
  int          n;
  logic [15:0] m_stage, m_shadow;
  logic [3:0]  m_stage_dp, m_shadow_dp;
  logic        m_pend, m_frame;
  int          checks = 0;
  int          fails = 0;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int idx);
    logic blank;
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && (m_shadow >> (4 * idx)) == 16'd0 && (m_shadow_dp >> idx) == 4'd0)
      blank = 1'b1;
`endif
    return blank ? 7'h7F : ~glyph[m_shadow[idx*4 +: 4]];
  endfunction

  task automatic check_all(input string tag);
    int idx;
    idx = (n / SD) % 4;
    chk({tag, "_an"},   {3'b0, an_n},   {3'b0, ~(4'b0001 << idx)});
    chk({tag, "_seg"},  seg_n,          exp_seg(idx));
    chk({tag, "_dp"},   {6'b0, dp_n},   {6'b0, ~m_shadow_dp[idx]});
    chk({tag, "_frm"},  {6'b0, frame_o}, {6'b0, m_frame});
    chk({tag, "_pend"}, {6'b0, pending_o}, {6'b0, m_pend});
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_an"},   {3'b0, an_n}, 7'h0F);
    chk({tag, "_seg"},  seg_n, 7'h7F);
    chk({tag, "_dp"},   {6'b0, dp_n}, 7'h01);
    chk({tag, "_frm"},  {6'b0, frame_o}, 7'h00);
    chk({tag, "_pend"}, {6'b0, pending_o}, 7'h00);
  endtask

  task automatic model_reset();
    n = 0; m_stage = '0; m_shadow = '0; m_stage_dp = '0; m_shadow_dp = '0;
    m_pend = 1'b0; m_frame = 1'b0;
  endtask

  // One clock edge: model sees the inputs held across the edge
  task automatic step(input string tag);
    logic bnd;
    @(posedge clk);
    n++;
    bnd = (n % (4 * SD)) == 0;
    if (bnd) begin
      if (upd_i) begin m_shadow = digits_i; m_shadow_dp = dp_i; end
      else if (m_pend) begin m_shadow = m_stage; m_shadow_dp = m_stage_dp; end
      m_pend = 1'b0;
    end else if (upd_i) begin
      m_pend = 1'b1;
    end
    if (upd_i) begin m_stage = digits_i; m_stage_dp = dp_i; end
    m_frame = bnd;
    #1;
    check_all(tag);
  endtask

  task automatic steps(input string tag, input int k);
    for (int i = 0; i < k; i++) step(tag);
  endtask

  task automatic pulse_upd(input string tag, input logic [15:0] d, input logic [3:0] p);
    digits_i = d; dp_i = p; upd_i = 1'b1;
    step(tag);
    upd_i = 1'b0;
  endtask

  // Advance until the next edge is a frame boundary
  task automatic to_pre_boundary(input string tag);
    while (((n + 1) % (4 * SD)) != 0) step(tag);
  endtask

  initial begin
    model_reset();
    #12;
    check_reset("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: idle scanning of zeros
    steps("idle", 4 * SD * 2);

    // 2: mid-frame update, pending until boundary
    steps("t2pre", 5);
    pulse_upd("t2upd", 16'h1234, 4'b0100);
    steps("t2run", 4 * SD * 2);

    // 3: back-to-back updates in one frame, last wins
    steps("t3pre", 2);
    pulse_upd("t3a", 16'hAAAA, 4'b0000);
    steps("t3mid", 2);
    pulse_upd("t3b", 16'h5555, 4'b0001);
    steps("t3run", 4 * SD * 2);

    // 4: update coincident with boundary
    to_pre_boundary("t4pre");
    pulse_upd("t4upd", 16'hC0DE, 4'b1010);
    steps("t4run", 4 * SD);

    // 5: async reset mid digit 2
    while (!(((n / SD) % 4) == 2 && (n % SD) == 1)) step("t5pre");
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("t5async");
    @(posedge clk);
    #1;
    check_reset("t5held");
    model_reset();
    rst_n = 1'b1;
    steps("t5run", 4 * SD);

    // 6: leading-zero patterns
    pulse_upd("t6a", 16'h0012, 4'b0000);
    to_pre_boundary("t6apre");
    steps("t6arun", 4 * SD + 1);
    pulse_upd("t6b", 16'h0012, 4'b1000);
    to_pre_boundary("t6bpre");
    steps("t6brun", 4 * SD + 1);
    pulse_upd("t6c", 16'h0000, 4'b0000);
    to_pre_boundary("t6cpre");
    steps("t6crun", 4 * SD + 1);

    // Random updates
    for (int i = 0; i < 300; i++) begin
      digits_i = 16'($urandom);
      dp_i     = 4'($urandom);
      if ($urandom_range(0, 3) == 0) digits_i[15:8] = 8'h00;
      upd_i    = ($urandom_range(0, 9) == 0);
      step("rand");
    end
    upd_i = 1'b0;

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
